// File: rtl/vga_pkg.sv
// vga_pkg: shared types, default 640x480@60 timing and helpers
// for the VGA timing generator.
package vga_pkg;

    typedef enum logic [1:0] {
        PAT_SOLID = 2'd0,
        PAT_BARS  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_GRAD  = 2'd3
    } pat_e;

    typedef struct packed {
        int active;
        int fp;
        int sync;
        int bp;
    } timing_t;

    localparam timing_t DEF_H = '{
        active: 640, fp: 16, sync: 96, bp: 48
    };
    localparam timing_t DEF_V = '{
        active: 480, fp: 10, sync: 2, bp: 33
    };
    localparam int DEF_CLK_DIV  = 2;
    localparam int DEF_COLOR_W  = 4;
    localparam int DEF_CHK_LOG2 = 5;

    function automatic int tm_total(timing_t t);
        return t.active + t.fp + t.sync + t.bp;
    endfunction

    function automatic bit tm_legal(timing_t t);
        return (t.active > 0) && (t.fp > 0) &&
               (t.sync > 0) && (t.bp > 0);
    endfunction

endpackage

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: test-pattern mux with the colour-bar counter,
// driven by the pixel counters and the latched pattern mode.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_TOTAL  = 800,
    parameter int COLOR_W  = 4,
    parameter int CHK_LOG2 = 5,
    parameter int HW       = 10,
    parameter int VW       = 10
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 pix_en,
    input  logic [HW-1:0]        hcnt,
    input  logic [VW-1:0]        vcnt,
    input  pat_e                 mode,
    input  logic [3*COLOR_W-1:0] solid_rgb,
    output logic [COLOR_W-1:0]   red,
    output logic [COLOR_W-1:0]   green,
    output logic [COLOR_W-1:0]   blue
);

    localparam int BAR_W = H_ACTIVE / 8;
    localparam int BW = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);

    logic [BW-1:0]      bar_px;
    logic [2:0]         bar;
    logic               chk;
    logic [COLOR_W-1:0] gr;
    logic [COLOR_W-1:0] gg;

    // bar index tracks hcnt: restart each line, step every BAR_W pixels
    always_ff @(posedge clk) begin
        if (clr) begin
            bar_px <= '0;
            bar    <= '0;
        end else if (pix_en) begin
            if (hcnt == H_LAST) begin
                bar_px <= '0;
                bar    <= '0;
            end else if (bar_px == BAR_LAST) begin
                bar_px <= '0;
                bar    <= bar + 3'd1;
            end else begin
                bar_px <= bar_px + BW'(1);
            end
        end
    end

    // pattern select; blanking is applied by the caller
    always_comb begin
        chk   = 1'(hcnt >> CHK_LOG2) ^ 1'(vcnt >> CHK_LOG2);
        gr    = COLOR_W'(hcnt >> 6);
        gg    = COLOR_W'(vcnt >> 5);
        red   = '0;
        green = '0;
        blue  = '0;
        unique case (mode)
            PAT_SOLID: {red, green, blue} = solid_rgb;
            PAT_BARS: begin
                red   = {COLOR_W{bar[2]}};
                green = {COLOR_W{bar[1]}};
                blue  = {COLOR_W{bar[0]}};
            end
            PAT_CHECK: begin
                red   = {COLOR_W{chk}};
                green = {COLOR_W{chk}};
                blue  = {COLOR_W{chk}};
            end
            PAT_GRAD: begin
                red   = gr;
                green = gg;
                blue  = gr ^ gg;
            end
        endcase
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing with pixel-clock enable,
// registered sync/blank/coordinates and frame-aligned pattern select.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   CLK_DIV  = DEF_CLK_DIV,
    parameter int   H_ACTIVE = DEF_H.active,
    parameter int   H_FP     = DEF_H.fp,
    parameter int   H_SYNC   = DEF_H.sync,
    parameter int   H_BP     = DEF_H.bp,
    parameter int   V_ACTIVE = DEF_V.active,
    parameter int   V_FP     = DEF_V.fp,
    parameter int   V_SYNC   = DEF_V.sync,
    parameter int   V_BP     = DEF_V.bp,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   COLOR_W  = DEF_COLOR_W,
    parameter int   CHK_LOG2 = DEF_CHK_LOG2,
    localparam int  HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    localparam int  VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic [1:0]           mode,
    input  logic [3*COLOR_W-1:0] solid_rgb,
    output logic [COLOR_W-1:0]   red,
    output logic [COLOR_W-1:0]   green,
    output logic [COLOR_W-1:0]   blue,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 de,
    output logic [HW-1:0]        x,
    output logic [VW-1:0]        y,
    output logic                 frame_start,
    output logic                 pix_en
);

    localparam timing_t H_TIM = '{
        active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP
    };
    localparam timing_t V_TIM = '{
        active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP
    };
    localparam int H_TOTAL = tm_total(H_TIM);
    localparam int V_TOTAL = tm_total(V_TIM);

    if (CLK_DIV < 1 || COLOR_W < 1 || CHK_LOG2 < 0 ||
        !tm_legal(H_TIM) || !tm_legal(V_TIM) ||
        (H_ACTIVE % 8) != 0) begin : g_bad_params
        $error("vga_timing_gen: illegal timing parameters");
    end

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_A    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_B   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_E   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_A    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_B   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_E   = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [DW-1:0]      div_cnt;
    logic [HW-1:0]      hcnt;
    logic [VW-1:0]      vcnt;
    logic               active;
    logic               hs_act;
    logic               vs_act;
    pat_e               mode_q;
    pat_e               mode_eff;
    logic [COLOR_W-1:0] pr;
    logic [COLOR_W-1:0] pg;
    logic [COLOR_W-1:0] pb;

    // Strobe is held low in reset so no frame_start can leak out
    assign pix_en = ~clr & (div_cnt == DIV_LAST);
    assign frame_start = pix_en & (hcnt == '0) & (vcnt == '0);

    assign active = (hcnt < H_A) && (vcnt < V_A);
    assign hs_act = (hcnt >= HS_B) && (hcnt < HS_E);
    assign vs_act = (vcnt >= VS_B) && (vcnt < VS_E);

    // The pixel at (0,0) already uses the mode being latched
    assign mode_eff = frame_start ? pat_e'(mode) : mode_q;

    // master-clock divider producing the pixel strobe
    always_ff @(posedge clk) begin
        if (clr || div_cnt == DIV_LAST) div_cnt <= '0;
        else div_cnt <= div_cnt + DW'(1);
    end

    // pixel and line counters, one step per pixel strobe
    always_ff @(posedge clk) begin
        if (clr) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (pix_en) begin
            if (hcnt == H_LAST) begin
                hcnt <= '0;
                vcnt <= (vcnt == V_LAST) ? '0 : vcnt + VW'(1);
            end else begin
                hcnt <= hcnt + HW'(1);
            end
        end
    end

    // pattern mode changes only at the frame boundary
    always_ff @(posedge clk) begin
        if (clr) mode_q <= PAT_SOLID;
        else if (frame_start) mode_q <= pat_e'(mode);
    end

    vga_pattern_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_TOTAL  (H_TOTAL),
        .COLOR_W  (COLOR_W),
        .CHK_LOG2 (CHK_LOG2),
        .HW       (HW),
        .VW       (VW)
    ) u_pat (
        .clk       (clk),
        .clr       (clr),
        .pix_en    (pix_en),
        .hcnt      (hcnt),
        .vcnt      (vcnt),
        .mode      (mode_eff),
        .solid_rgb (solid_rgb),
        .red       (pr),
        .green     (pg),
        .blue      (pb)
    );

    // registered output stage, one pixel slot behind the counters
    always_ff @(posedge clk) begin
        if (clr) begin
            hsync <= ~HS_POL;
            vsync <= ~VS_POL;
            de    <= 1'b0;
            red   <= '0;
            green <= '0;
            blue  <= '0;
            x     <= '0;
            y     <= '0;
        end else if (pix_en) begin
            hsync <= hs_act ? HS_POL : ~HS_POL;
            vsync <= vs_act ? VS_POL : ~VS_POL;
            de    <= active;
            red   <= active ? pr : '0;
            green <= active ? pg : '0;
            blue  <= active ? pb : '0;
            x     <= hcnt;
            y     <= vcnt;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed table-driven bench on a reduced
// 128x36 timing (160x40 total) so several frames fit in the run.
module tb_vga_timing_gen;

    localparam int HA = 128, HF = 8, HS = 16, HB = 8;
    localparam int VA = 36, VF = 1, VS = 2, VB = 1;
    localparam int HT = 160, VT = 40;
    localparam int FR = HT * VT;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic [11:0] solid_rgb = 12'hA5C;
    logic [3:0]  red, green, blue;
    logic        hsync, vsync, de, frame_start, pix_en;
    logic [7:0]  x;
    logic [5:0]  y;

    logic [1:0]  f_mode = 2'd0;
    logic [11:0] f_solid = 12'h123;
    logic [3:0]  f_red, f_green, f_blue;
    logic        f_hsync, f_vsync, f_de, f_fs, f_pix_en;
    logic [7:0]  f_x;
    logic [5:0]  f_y;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit go = 1'b0;
    bit done2 = 1'b0;

    typedef struct {
        int          f;
        int          px;
        int          py;
        logic [1:0]  md;
        logic [11:0] rgb;
        logic        de;
        logic        hs;
        logic        vs;
    } vec_t;

    vec_t q[$];

    vga_timing_gen #(
        .CLK_DIV(2), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS),
        .H_BP(HB), .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS),
        .V_BP(VB), .HS_POL(1'b0), .VS_POL(1'b0),
        .COLOR_W(4), .CHK_LOG2(3)
    ) dut (
        .clk(clk), .clr(clr), .mode(mode),
        .solid_rgb(solid_rgb), .red(red), .green(green),
        .blue(blue), .hsync(hsync), .vsync(vsync), .de(de),
        .x(x), .y(y), .frame_start(frame_start),
        .pix_en(pix_en)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS),
        .H_BP(HB), .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS),
        .V_BP(VB), .HS_POL(1'b1), .VS_POL(1'b1),
        .COLOR_W(4), .CHK_LOG2(3)
    ) dut_fast (
        .clk(clk), .clr(clr), .mode(f_mode),
        .solid_rgb(f_solid), .red(f_red), .green(f_green),
        .blue(f_blue), .hsync(f_hsync), .vsync(f_vsync),
        .de(f_de), .x(f_x), .y(f_y), .frame_start(f_fs),
        .pix_en(f_pix_en)
    );

    always #5 clk = ~clk;

    // clocks since clr was last released
    always @(posedge clk) begin
        if (clr) cyc <= 0;
        else cyc <= cyc + 1;
    end

    task automatic check1(input string nm,
                          input logic [31:0] act,
                          input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    task automatic waitc(input int target);
        int g = 0;
        while (cyc < target && g < 200000) begin
            @(negedge clk);
            g++;
        end
        check1("reach_cycle", cyc, target);
    endtask

    task automatic add(input int f, input int px, input int py,
                       input logic [1:0] md,
                       input logic [11:0] rgb,
                       input logic de_e, input logic hs_e,
                       input logic vs_e);
        vec_t v;
        v.f = f; v.px = px; v.py = py; v.md = md;
        v.rgb = rgb; v.de = de_e; v.hs = hs_e; v.vs = vs_e;
        q.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: timeout, tests=%0d fails=%0d",
                 tests, fails);
        $fatal(1, "watchdog");
    end

    // fast instance sync shape and frame period checks
    initial begin
        wait (go);
        waitc(136);
        check1("f_hs_idle", f_hsync, 1'b0);
        check1("f_pix_en", f_pix_en, 1'b1);
        waitc(137);
        check1("f_hs_rise", f_hsync, 1'b1);
        check1("f_x136", f_x, 136);
        waitc(152);
        check1("f_hs_last", f_hsync, 1'b1);
        waitc(153);
        check1("f_hs_end", f_hsync, 1'b0);
        waitc(5920);
        check1("f_vs_idle", f_vsync, 1'b0);
        waitc(5921);
        check1("f_vs_on", f_vsync, 1'b1);
        waitc(FR - 1);
        check1("f_fs_pre", f_fs, 1'b0);
        waitc(FR);
        check1("f_fs_per", f_fs, 1'b1);
        check1("f_pix_en2", f_pix_en, 1'b1);
        waitc(FR + 1);
        check1("f_fs_post", f_fs, 1'b0);
        waitc(2 * FR);
        check1("fs_pre", frame_start, 1'b0);
        waitc(2 * FR + 1);
        check1("fs_per", frame_start, 1'b1);
        check1("pix_en_hi", pix_en, 1'b1);
        waitc(2 * FR + 2);
        check1("fs_post", frame_start, 1'b0);
        check1("pix_en_lo", pix_en, 1'b0);
        done2 = 1'b1;
    end

    initial begin
        // frame 0: solid, then a mid-frame switch to checker
        add(0,   0,  0, 2'd0, 12'hA5C, 1, 1, 1);
        add(0, 127,  5, 2'd0, 12'hA5C, 1, 1, 1);
        add(0, 128,  5, 2'd0, 12'h000, 0, 1, 1);
        add(0, 135,  5, 2'd0, 12'h000, 0, 1, 1);
        add(0, 136,  5, 2'd0, 12'h000, 0, 0, 1);
        add(0, 151,  5, 2'd0, 12'h000, 0, 0, 1);
        add(0, 152,  5, 2'd0, 12'h000, 0, 1, 1);
        add(0,  20, 12, 2'd2, 12'hA5C, 1, 1, 1);
        add(0, 127, 35, 2'd2, 12'hA5C, 1, 1, 1);
        add(0,   0, 36, 2'd2, 12'h000, 0, 1, 1);
        add(0, 159, 36, 2'd2, 12'h000, 0, 1, 1);
        add(0,   0, 37, 2'd2, 12'h000, 0, 1, 0);
        add(0,  80, 38, 2'd2, 12'h000, 0, 1, 0);
        add(0,   0, 39, 2'd2, 12'h000, 0, 1, 1);
        // frame 1: checkerboard, 8-pixel squares
        add(1,   7,  0, 2'd2, 12'h000, 1, 1, 1);
        add(1,   8,  0, 2'd2, 12'hFFF, 1, 1, 1);
        add(1,   0,  8, 2'd2, 12'hFFF, 1, 1, 1);
        add(1,   8,  8, 2'd2, 12'h000, 1, 1, 1);
        add(1, 100, 20, 2'd2, 12'h000, 1, 1, 1);
        add(1, 104, 20, 2'd1, 12'hFFF, 1, 1, 1);
        // frame 2: colour bars, 16 pixels wide
        add(2,   0,  3, 2'd1, 12'h000, 1, 1, 1);
        add(2,  16,  3, 2'd1, 12'h00F, 1, 1, 1);
        add(2,  31,  3, 2'd1, 12'h00F, 1, 1, 1);
        add(2,  32,  3, 2'd1, 12'h0F0, 1, 1, 1);
        add(2,  80,  3, 2'd1, 12'hF0F, 1, 1, 1);
        add(2, 127,  3, 2'd1, 12'hFFF, 1, 1, 1);
        add(2, 128,  3, 2'd1, 12'h000, 0, 1, 1);
        add(2,   0,  4, 2'd1, 12'h000, 1, 1, 1);
        add(2, 112,  4, 2'd3, 12'hFFF, 1, 1, 1);
        // frame 3: gradient
        add(3,  63, 10, 2'd3, 12'h000, 1, 1, 1);
        add(3,  64, 10, 2'd3, 12'h101, 1, 1, 1);
        add(3,  70, 33, 2'd3, 12'h110, 1, 1, 1);
        add(3,  10, 35, 2'd3, 12'h011, 1, 1, 1);
        add(3,  50, 37, 2'd3, 12'h000, 0, 1, 0);

        repeat (3) begin
            @(negedge clk);
            check1("rst_fs", frame_start, 1'b0);
            check1("rst_f_fs", f_fs, 1'b0);
        end
        check1("rst_pix_en", pix_en, 1'b0);
        check1("rst_f_pix_en", f_pix_en, 1'b0);
        check1("rst_sync", {hsync, vsync}, 2'b11);
        check1("rst_f_sync", {f_hsync, f_vsync}, 2'b00);
        check1("rst_de_rgb", {de, red, green, blue}, 13'h0);
        check1("rst_xy", {x, y}, 14'h0);

        clr = 1'b0;
        #1;
        check1("rel_f_pix_en", f_pix_en, 1'b1);
        check1("rel_f_fs", f_fs, 1'b1);
        check1("rel_pix_en", pix_en, 1'b0);
        check1("rel_fs", frame_start, 1'b0);
        go = 1'b1;
        waitc(1);
        check1("first_pix_en", pix_en, 1'b1);
        check1("first_fs", frame_start, 1'b1);
        waitc(2);
        check1("second_pix_en", pix_en, 1'b0);
        check1("second_fs", frame_start, 1'b0);

        foreach (q[i]) begin
            mode = q[i].md;
            waitc(2 * (q[i].f * FR + q[i].py * HT + q[i].px + 1));
            tests++;
            if ({red, green, blue, de, hsync, vsync, x, y} !==
                {q[i].rgb, q[i].de, q[i].hs, q[i].vs,
                 8'(q[i].px), 6'(q[i].py)}) begin
                fails++;
                $display("FAIL vec%0d f%0d (%0d,%0d): got rgb=%h de=%b hs=%b vs=%b x=%0d y=%0d, want rgb=%h de=%b hs=%b vs=%b",
                         i, q[i].f, q[i].px, q[i].py,
                         {red, green, blue}, de, hsync, vsync,
                         x, y, q[i].rgb, q[i].de, q[i].hs, q[i].vs);
            end
        end

        // one-clock reset in the middle of a frame
        clr = 1'b1;
        @(negedge clk);
        check1("mid_rst_xy", {x, y}, 14'h0);
        check1("mid_rst_sync", {hsync, vsync}, 2'b11);
        check1("mid_rst_de_rgb", {de, red, green, blue}, 13'h0);
        check1("mid_rst_fs", frame_start, 1'b0);
        check1("mid_rst_f_x", f_x, 8'h0);
        check1("mid_rst_f_sync", {f_hsync, f_vsync}, 2'b00);
        clr = 1'b0;
        #1;
        check1("mid_rel_fs", frame_start, 1'b0);
        waitc(1);
        check1("mid_first_fs", frame_start, 1'b1);
        waitc(2);
        check1("mid_restart", {x, y, de}, {8'd0, 6'd0, 1'b1});
        waitc(4);
        check1("mid_x1", x, 8'd1);
        check1("seq2_done", done2, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
